// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the FSM encoding, the hard-wired zero register and the watchdog width.
package hazard_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hazard_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int         WAIT_W   = 16;

    // True when an ID source operand is read and names the given destination.
    function automatic logic src_match(input logic       uses,
                                       input logic [4:0] src,
                                       input logic [4:0] dst);
        return uses && (src == dst);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
// Stops at all-ones and never wraps back to zero.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hazard_detection_unit.sv
// Stall/flush controller for the 5-stage pipeline: load-use, taken branch and
// memory-wait hazards, plus a memory-wait watchdog and stall/flush counters.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RUN      | normal issue; load-use and branch hazards handled here
// MEM_WAIT | a data-memory access in MEM is outstanding; back end frozen
module hazard_detection_unit
    import hazard_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_uses_Rs,
    input  logic             ID_uses_Rt,
    input  logic             EX_mem_read,
    input  logic [4:0]       EX_Rd,
    input  logic             EX_branch_taken,
    input  logic             MEM_mem_access,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             IF_ID_write,
    output logic             ID_EX_bubble,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush,
    output logic             pipe_freeze,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [WAIT_W-1:0] TIMEOUT_LIMIT = WAIT_W'(MEM_TIMEOUT);

    hazard_state_t     state;
    hazard_state_t     state_next;
    logic              mem_wait;
    logic              load_use;
    logic              freeze;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_inc;

    assign mem_wait = MEM_mem_access && !dmem_ready;
    assign load_use = EX_mem_read && (EX_Rd != REG_ZERO) &&
                      (src_match(ID_uses_Rs, ID_Rs, EX_Rd) ||
                       src_match(ID_uses_Rt, ID_Rt, EX_Rd));

    // Once waiting, the access stays in MEM until dmem_ready, so hold on that alone.
    assign freeze = mem_wait || ((state == MEM_WAIT) && !dmem_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        pc_write     = 1'b1;
        IF_ID_write  = 1'b1;
        ID_EX_bubble = 1'b0;
        IF_ID_flush  = 1'b0;
        ID_EX_flush  = 1'b0;
        pipe_freeze  = 1'b0;

        case (state)
            RUN:      if (mem_wait)   state_next = MEM_WAIT;
            MEM_WAIT: if (dmem_ready) state_next = RUN;
            default:                  state_next = RUN;
        endcase

        if (rst) begin
            state_next = RUN;
        end else if (freeze) begin
            pipe_freeze = 1'b1;
            pc_write    = 1'b0;
            IF_ID_write = 1'b0;
        end else if (EX_branch_taken) begin
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
        end else if (load_use) begin
            pc_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_bubble = 1'b1;
        end
    end

    assign wait_inc = (wait_cnt == {WAIT_W{1'b1}}) ? wait_cnt : wait_cnt + WAIT_W'(1);

    // wait_cnt holds the number of frozen cycles completed so far in this wait.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else if (freeze) begin
            wait_cnt <= wait_inc;
            if (wait_inc >= TIMEOUT_LIMIT) begin
                mem_timeout <= 1'b1;
            end
        end else begin
            wait_cnt <= '0;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (!pc_write),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (IF_ID_flush),
        .count (flush_count)
    );

endmodule

// File: doc/hazard_detection_unit.md
# hazard_detection_unit

Pipeline stall/flush controller for the 5-stage MIPS core, the counterpart to forwarding. It detects the hazards forwarding cannot resolve: load-use dependencies, taken branches and multi-cycle data-memory accesses. For each it drives the PC/IF_ID write enables, the ID_EX bubble, the IF_ID/ID_EX flushes and the MEM freeze. It also keeps a memory-wait watchdog and saturating stall/flush performance counters for debug.

## Interface
Parameters:
- CNT_W, 16, width of the performance counters
- MEM_TIMEOUT, 255, consecutive memory-wait cycles before `mem_timeout` is raised; legal range is 1..2^16-1

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- rst  in  1  reset, synchronous and active-high
- ID_Rs  in  5  source register Rs of the instruction in ID
- ID_Rt  in  5  source register Rt of the instruction in ID
- ID_uses_Rs  in  1  the ID instruction reads Rs
- ID_uses_Rt  in  1  the ID instruction reads Rt
- EX_mem_read  in  1  the instruction in EX is a load
- EX_Rd  in  5  destination register of the instruction in EX
- EX_branch_taken  in  1  branch or jump resolved taken in EX
- MEM_mem_access  in  1  the instruction in MEM is a load or store
- dmem_ready  in  1  data memory completes the access this cycle
- pc_write  out  1  PC update enable
- IF_ID_write  out  1  IF_ID register write enable
- ID_EX_bubble  out  1  insert a NOP into ID_EX
- IF_ID_flush  out  1  squash the IF_ID contents
- ID_EX_flush  out  1  squash the ID_EX contents
- pipe_freeze  out  1  hold the EX_MEM and MEM_WB registers
- mem_timeout  out  1  sticky watchdog error
- stall_cycles  out  CNT_W  count of cycles with `pc_write`=0
- flush_count  out  CNT_W  count of cycles with `IF_ID_flush`=1

## Operation
Hazard conditions:
- mem_wait = MEM_mem_access && !dmem_ready
- load_use = EX_mem_read && EX_Rd!=0 && ((ID_uses_Rs && ID_Rs==EX_Rd) || (ID_uses_Rt && ID_Rt==EX_Rd))

Control outputs are combinational from the FSM state and the inputs. Priority, highest first:
1. mem_wait: pipe_freeze=1, pc_write=0, IF_ID_write=0. All bubble and flush outputs are 0; a pending branch or load-use is re-evaluated after the release.
2. EX_branch_taken: IF_ID_flush=1, ID_EX_flush=1, pc_write=1, IF_ID_write=1. load_use is ignored because the ID instruction is squashed.
3. load_use: pc_write=0, IF_ID_write=0, ID_EX_bubble=1.
4. Otherwise: pc_write=1, IF_ID_write=1, all other control outputs 0.

FSM states:
- RUN → MEM_WAIT when mem_wait.
- MEM_WAIT → RUN when dmem_ready.
- MEM_WAIT → MEM_WAIT otherwise.

Watchdog:
- wait_cnt (16 bit) counts consecutive cycles with mem_wait=1. The RUN cycle that first sees mem_wait counts as cycle 1.
- wait_cnt clears whenever mem_wait=0.
- When wait_cnt reaches MEM_TIMEOUT, mem_timeout sets. It stays set until rst. The freeze continues.

Counters:
- stall_cycles +1 on every non-reset cycle with pc_write=0.
- flush_count +1 on every non-reset cycle with IF_ID_flush=1.
- Both saturate at 2^CNT_W-1 and never wrap.

Reset:
- While rst=1, outputs are forced to pc_write=1, IF_ID_write=1, all other control outputs 0.
- Next state RUN; wait_cnt, counters and mem_timeout cleared.
- Reset asserted mid-MEM_WAIT drops the freeze in that same cycle.

## Timing
- Stall, bubble, flush and freeze outputs have zero latency (same cycle as the causing inputs). State and counters update on the next edge.
- Load-use: exactly 1 stall cycle per dependent pair. The next cycle the load is in MEM and load_use is false.
- Memory wait: freeze lasts exactly N cycles for N consecutive cycles of !dmem_ready. The cycle with dmem_ready=1 is not frozen.
- mem_timeout rises on the edge ending the MEM_TIMEOUT-th frozen cycle.
- Register 0 never causes a stall.

## Structure
- Package hazard_pkg holds the FSM state encoding (RUN=1'b0, MEM_WAIT=1'b1), REG_ZERO=5'd0 and the watchdog width (16).
- Sub-module sat_counter (parameter W; ports clk, rst, inc, count) is instantiated twice, for stall_cycles and flush_count.

## Test plan
- Load to $5 in EX, ID uses Rt=$5 → exactly 1 cycle of pc_write=0, ID_EX_bubble=1; stall_cycles 0→1.
- Load to $0 in EX, ID uses Rs=$0 → no stall; all enables stay 1.
- EX_branch_taken=1 together with load_use → IF_ID_flush=ID_EX_flush=1, pc_write=1, no bubble; flush_count +1.
- mem_wait held for 3 cycles, then dmem_ready=1 → pipe_freeze=1 for exactly 3 cycles; state RUN after release; stall_cycles +3.
- MEM_TIMEOUT=4, dmem_ready held 0 → mem_timeout=1 after the 4th frozen cycle and stays set once dmem_ready returns; rst clears it.
- CNT_W=2 with 5 stall cycles → stall_cycles saturates at 3; rst asserted mid-freeze → freeze drops the same cycle and counters read 0.
